// File: rtl/iz_param_loader_multi_if.sv
// Handshake/bus bundle for the multi-set Izhikevich parameter loader.
// The master drives the serial frame inputs; the slave (loader) returns params and status.
interface iz_param_loader_multi_if #(
    parameter int PARAM_W  = 8,
    parameter int NUM_SETS = 4
);
    logic                           enable;
    logic                           serial_data_in;
    logic                           load_enable;
    logic [NUM_SETS*4*PARAM_W-1:0]  params_flat;
    logic                           params_ready;
    logic                           commit_pulse;
    logic                           frame_error;
    logic                           busy;

    modport master (
        output enable, serial_data_in, load_enable,
        input  params_flat, params_ready, commit_pulse, frame_error, busy
    );

    modport slave (
        input  enable, serial_data_in, load_enable,
        output params_flat, params_ready, commit_pulse, frame_error, busy
    );
endinterface

// File: rtl/iz_param_loader_multi.sv
// Serial loader for NUM_SETS Izhikevich (a,b,c,d) parameter sets: addressed frames,
// XOR checksum, shadow staging with atomic commit, abort detection and a sticky error flag.
module iz_param_loader_multi #(
    parameter int PARAM_W  = 8,
    parameter int NUM_SETS = 4,
    parameter int ADDR_W   = 2,
    parameter int DEF_A    = 26,
    parameter int DEF_B    = 26,
    parameter int DEF_C    = 63,
    parameter int DEF_D    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    iz_param_loader_multi_if.slave  bus
);
    localparam int SET_W = 4 * PARAM_W;
    localparam int CNT_W = $clog2(SET_W + 1);
    localparam logic [SET_W-1:0] DEF_SET = {PARAM_W'(DEF_A), PARAM_W'(DEF_B),
                                            PARAM_W'(DEF_C), PARAM_W'(DEF_D)};

    typedef enum logic [2:0] {IDLE, ADDR, DATA, CHK, WAIT_LOW} state_e;

    state_e                           state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [ADDR_W-1:0]                addr_q, addr_d;
    logic [SET_W-1:0]                 stage_q, stage_d;
    logic [PARAM_W-1:0]               chk_q, chk_d;
    logic [NUM_SETS-1:0][SET_W-1:0]   sets_q, sets_d;
    logic                             ready_q, ready_d;
    logic                             commit_q, commit_d;
    logic                             err_q, err_d;
    logic                             le_prev_q;

    logic               rise, start, sum_ok, addr_ok;
    logic [PARAM_W-1:0] pa, pb, pc, pd, chk_full;

    function automatic logic [PARAM_W-1:0] nz(input logic [PARAM_W-1:0] v);
        return (v == '0) ? PARAM_W'(1) : v;
    endfunction

    assign rise     = bus.load_enable & ~le_prev_q;
    assign start    = rise && (state_q == IDLE || state_q == WAIT_LOW);
    assign pa       = stage_q[SET_W-1 -: PARAM_W];
    assign pb       = stage_q[3*PARAM_W-1 -: PARAM_W];
    assign pc       = stage_q[2*PARAM_W-1 -: PARAM_W];
    assign pd       = stage_q[PARAM_W-1:0];
    assign chk_full = PARAM_W'({chk_q, bus.serial_data_in});
    assign sum_ok   = (chk_full == (pa ^ pb ^ pc ^ pd));
    assign addr_ok  = (int'(addr_q) < NUM_SETS);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        stage_d  = stage_q;
        chk_d    = chk_q;
        sets_d   = sets_q;
        ready_d  = ready_q;
        err_d    = err_q;
        commit_d = 1'b0;
        if (bus.enable) begin
            if (start) begin
                state_d = ADDR;
                cnt_d   = '0;
                stage_d = '0;
                ready_d = 1'b0;
            end else if (state_q == WAIT_LOW) begin
                if (!bus.load_enable) state_d = IDLE;
            end else if (state_q != IDLE) begin
                if (!bus.load_enable) begin
                    // Abort: staging is thrown away, active sets stay untouched.
                    state_d = IDLE;
                    cnt_d   = '0;
                    stage_d = '0;
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    case (state_q)
                        ADDR: begin
                            addr_d = ADDR_W'({addr_q, bus.serial_data_in});
                            if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                                state_d = DATA;
                                cnt_d   = '0;
                            end
                        end
                        DATA: begin
                            stage_d = SET_W'({stage_q, bus.serial_data_in});
                            if (cnt_q == CNT_W'(SET_W - 1)) begin
                                state_d = CHK;
                                cnt_d   = '0;
                            end
                        end
                        CHK: begin
                            chk_d = chk_full;
                            if (cnt_q == CNT_W'(PARAM_W - 1)) begin
                                state_d = WAIT_LOW;
                                cnt_d   = '0;
                                ready_d = 1'b1;
                                if (sum_ok && addr_ok) begin
                                    for (int k = 0; k < NUM_SETS; k++)
                                        if (int'(addr_q) == k)
                                            sets_d[k] = {nz(pa), nz(pb), pc, nz(pd)};
                                    commit_d = 1'b1;
                                    err_d    = 1'b0;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            stage_q   <= '0;
            chk_q     <= '0;
            sets_q    <= {NUM_SETS{DEF_SET}};
            ready_q   <= 1'b1;
            commit_q  <= 1'b0;
            err_q     <= 1'b0;
            le_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            stage_q   <= stage_d;
            chk_q     <= chk_d;
            sets_q    <= sets_d;
            ready_q   <= ready_d;
            commit_q  <= commit_d;
            err_q     <= err_d;
            le_prev_q <= bus.load_enable;
        end
    end

    assign bus.params_flat  = sets_q;
    assign bus.params_ready = ready_q;
    assign bus.commit_pulse = commit_q;
    assign bus.frame_error  = err_q;
    assign bus.busy         = (state_q == ADDR) || (state_q == DATA) || (state_q == CHK);
endmodule
